key_schedule_stream: RTL and testbench

KEY_SCHEDULE_STREAM -- requirements
Module: key_schedule_stream

---
 rtl/key_schedule_stream.sv | 153 +++++++++++++++
 tb/tb_key_schedule_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_stream.sv
// Streaming key schedule: expands one master key into ROUND round keys behind a
// valid/ready handshake. Define KS_REPLAY_EN to add a key bank and a replay input.
module key_schedule_stream #(
    parameter int ROUND    = 5,
    parameter int KEY_SIZE = 128,
    parameter int ROT      = 13,
    localparam int IDX_W   = (ROUND > 2) ? $clog2(ROUND) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tvalid,
    output logic                tready,
    input  logic [KEY_SIZE-1:0] key,
    output logic                valid,
    input  logic                rk_ready,
    output logic [KEY_SIZE-1:0] rk,
    output logic [IDX_W-1:0]    rk_idx,
    output logic                rk_last
`ifdef KS_REPLAY_EN
    ,
    input  logic                replay
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUND - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                start_key;
    logic                advance;
    logic [IDX_W-1:0]    idx_inc;
    logic [KEY_SIZE-1:0] sched_key;
    logic [KEY_SIZE-1:0] next_rk;

    function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] k);
        return (k << ROT) | (k >> (KEY_SIZE - ROT));
    endfunction

    // i+1 never exceeds ROUND-1, so the incremented index zero-extends cleanly.
    assign idx_inc   = rk_idx + IDX_W'(1);
    assign sched_key = rotl(rk) ^ KEY_SIZE'(idx_inc);

`ifdef KS_REPLAY_EN
    logic                start_replay;
    logic                replay_mode;
    logic                key_loaded;
    logic [KEY_SIZE-1:0] bank [ROUND];

    assign next_rk = replay_mode ? bank[idx_inc] : sched_key;
`else
    assign next_rk = sched_key;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        valid     = 1'b0;
        start_key = 1'b0;
        advance   = 1'b0;
`ifdef KS_REPLAY_EN
        start_replay = 1'b0;
`endif
        case (state)
            IDLE: begin
                tready = 1'b1;
                if (tvalid) begin
                    start_key = 1'b1;
                    state_nxt = RUN;
                end
`ifdef KS_REPLAY_EN
                else if (replay && key_loaded) begin
                    start_replay = 1'b1;
                    state_nxt    = RUN;
                end
`endif
            end
            RUN: begin
                valid = 1'b1;
                if (rk_ready) begin
                    if (rk_idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rk_last = valid && (rk_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rk     <= '0;
            rk_idx <= '0;
        end else if (start_key) begin
            rk     <= key;
            rk_idx <= '0;
        end
`ifdef KS_REPLAY_EN
        else if (start_replay) begin
            rk     <= bank[0];
            rk_idx <= '0;
        end
`endif
        else if (advance) begin
            rk     <= next_rk;
            rk_idx <= idx_inc;
        end
    end

`ifdef KS_REPLAY_EN
    // NOTE: the bank is reset explicitly because stored keys must not survive a
    // reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROUND; i++) begin
                bank[i] <= '0;
            end
            replay_mode <= 1'b0;
            key_loaded  <= 1'b0;
        end else if (start_key) begin
            bank[0]     <= key;
            replay_mode <= 1'b0;
            key_loaded  <= 1'b1;
        end else if (start_replay) begin
            replay_mode <= 1'b1;
        end else if (advance && !replay_mode) begin
            bank[idx_inc] <= sched_key;
        end
    end
`endif

endmodule

// File: tb/tb_key_schedule_stream.sv
// Scoreboard bench for key_schedule_stream at default parameters; expected round
// keys are queued when a master key is sent and popped on each accepted rk.
`timescale 1ns/1ps
module tb_key_schedule_stream;

    localparam int ROUND    = 5;
    localparam int KEY_SIZE = 128;
    localparam int IDX_W    = 3;

    typedef struct packed {
        logic [KEY_SIZE-1:0] rk;
        logic [IDX_W-1:0]    idx;
        logic                last;
    } exp_t;

    logic                clk      = 1'b0;
    logic                reset_n  = 1'b0;
    logic                tvalid   = 1'b0;
    logic                tready;
    logic [KEY_SIZE-1:0] key      = '0;
    logic                valid;
    logic                rk_ready = 1'b0;
    logic [KEY_SIZE-1:0] rk;
    logic [IDX_W-1:0]    rk_idx;
    logic                rk_last;
    logic                replay   = 1'b0;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    key_schedule_stream dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tvalid   (tvalid),
        .tready   (tready),
        .key      (key),
        .valid    (valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
`ifdef KS_REPLAY_EN
        ,
        .replay   (replay)
`endif
    );

    function automatic logic [KEY_SIZE-1:0] model_next(input logic [KEY_SIZE-1:0] k, input int i);
        logic [KEY_SIZE-1:0] inc;
        inc      = '0;
        inc[7:0] = 8'(i + 1);
        return {k[KEY_SIZE-14:0], k[KEY_SIZE-1:KEY_SIZE-13]} ^ inc;
    endfunction

    task automatic push_stream(input logic [KEY_SIZE-1:0] k);
        logic [KEY_SIZE-1:0] cur;
        cur = k;
        for (int i = 0; i < ROUND; i++) begin
            exp_q.push_back({cur, IDX_W'(i), (i == ROUND - 1)});
            cur = model_next(cur, i);
        end
    endtask

    task automatic observe();
        exp_t e;
        if (valid === 1'b1 && rk_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rk_extra: got idx=%0d rk=%h, required no output", rk_idx, rk);
            end else begin
                e = exp_q.pop_front();
                if ({rk, rk_idx, rk_last} !== e) begin
                    n_bad++;
                    $display("FAIL rk_stream: got rk=%h idx=%0d last=%b, required rk=%h idx=%0d last=%b",
                             rk, rk_idx, rk_last, e.rk, e.idx, e.last);
                end
            end
        end
    endtask

    task automatic send_key(input logic [KEY_SIZE-1:0] k);
        int n = 0;
        while (tready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (tready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tready_timeout: got tready=%b, required 1", tready);
        end
        tvalid = 1'b1;
        key    = k;
        push_stream(k);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    // mode 0: rk_ready held high; mode 1: rk_ready toggles starting low.
    task automatic drain(input int mode, input int budget, output int n_acc);
        bit                        held = 0;
        logic [KEY_SIZE+IDX_W:0]   hold_v;
        n_acc = 0;
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && valid !== 1'b1) break;
            rk_ready = (mode == 0) ? 1'b1 : 1'(c % 2);
            if (held) begin
                n_cmp++;
                if ({rk, rk_idx, rk_last} !== hold_v) begin
                    n_bad++;
                    $display("FAIL rk_stall_hold: got %h, required %h", {rk, rk_idx, rk_last}, hold_v);
                end
            end
            held = 0;
            if (valid === 1'b1 && rk_ready === 1'b0) begin
                held   = 1;
                hold_v = {rk, rk_idx, rk_last};
            end
            if (valid === 1'b1 && rk_ready === 1'b1) n_acc++;
            observe();
            @(negedge clk);
        end
        rk_ready = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || valid !== 1'b0 || tready !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_complete: got pending=%0d valid=%b tready=%b, required 0/0/1",
                     exp_q.size(), valid, tready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({valid, rk, rk_idx, rk_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b rk=%h idx=%0d last=%b, required all 0",
                     valid, rk, rk_idx, rk_last);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tready !== 1'b1 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got tready=%b valid=%b, required 1/0", tready, valid);
        end
`ifdef KS_REPLAY_EN
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL replay_unloaded: got valid=%b, required 0", valid);
        end
`endif
    endtask

    task automatic test_zero_key();
        int n;
        logic [KEY_SIZE-1:0] k4;
        k4 = 128'h8008006004;
        tvalid = 1'b1;
        key    = '0;
        exp_q.push_back({128'h0,       3'd0, 1'b0});
        exp_q.push_back({128'h1,       3'd1, 1'b0});
        exp_q.push_back({128'h2002,    3'd2, 1'b0});
        exp_q.push_back({128'h4004003, 3'd3, 1'b0});
        exp_q.push_back({k4,           3'd4, 1'b1});
        @(negedge clk);
        tvalid = 1'b0;
        drain(0, 20, n);
        n_cmp++;
        if (n != ROUND) begin
            n_bad++;
            $display("FAIL zero_key_cycles: got %0d accepts, required %0d", n, ROUND);
        end
    endtask

    task automatic test_first_key();
        int n;
        logic [KEY_SIZE-1:0] k;
        k = 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333;
        send_key(k);
        n_cmp++;
        if (valid !== 1'b1 || rk !== k || rk_idx !== '0 || tready !== 1'b0) begin
            n_bad++;
            $display("FAIL first_rk_latency: got valid=%b rk=%h idx=%0d tready=%b, required 1/%h/0/0",
                     valid, rk, rk_idx, tready, k);
        end
        drain(0, 20, n);
    endtask

    task automatic test_stall();
        int n;
        send_key(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        drain(1, 40, n);
        n_cmp++;
        if (n != ROUND) begin
            n_bad++;
            $display("FAIL stall_count: got %0d accepts, required %0d", n, ROUND);
        end
    endtask

    task automatic test_ignore_second();
        bit pulsed = 0;
        send_key(128'h11112222_33334444_55556666_77778888);
        for (int c = 0; c < 30; c++) begin
            if (exp_q.size() == 0 && valid !== 1'b1) break;
            rk_ready = 1'b1;
            tvalid   = 1'b0;
            if (!pulsed && valid === 1'b1 && rk_idx === 3'd2) begin
                pulsed = 1;
                tvalid = 1'b1;
                key    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
                n_cmp++;
                if (tready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_tready: got tready=%b, required 0", tready);
                end
            end
            observe();
            @(negedge clk);
        end
        tvalid   = 1'b0;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!pulsed || exp_q.size() != 0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_second: got pulsed=%0d pending=%0d valid=%b, required 1/0/0",
                     pulsed, exp_q.size(), valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit hit = 0;
        send_key(128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE);
        for (int c = 0; c < 20; c++) begin
            if (valid === 1'b1 && rk_idx === 3'd3) begin
                hit = 1;
                break;
            end
            rk_ready = 1'b1;
            observe();
            @(negedge clk);
        end
        rk_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (!hit || valid !== 1'b0 || rk !== '0 || rk_idx !== '0 || rk_last !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got hit=%0d valid=%b rk=%h idx=%0d last=%b, required 1/0/0/0/0",
                     hit, valid, rk, rk_idx, rk_last);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_key(128'h55AA55AA_00FF00FF_F0F0F0F0_12121212);
        drain(0, 20, n);
    endtask

`ifdef KS_REPLAY_EN
    task automatic test_replay();
        int n;
        logic [KEY_SIZE-1:0] k;
        k = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        send_key(k);
        drain(0, 20, n);
        replay = 1'b1;
        push_stream(k);
        @(negedge clk);
        replay = 1'b0;
        drain(1, 40, n);
        n_cmp++;
        if (n != ROUND) begin
            n_bad++;
            $display("FAIL replay_count: got %0d accepts, required %0d", n, ROUND);
        end
        replay = 1'b1;
        send_key(128'h00000000_00000000_00000000_0000BEEF);
        replay = 1'b0;
        drain(0, 20, n);
    endtask
`endif

    initial begin
        int dummy;
        test_reset();
        test_zero_key();
        test_first_key();
        test_stall();
        test_ignore_second();
        test_reset_mid();
`ifdef KS_REPLAY_EN
        test_replay();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
